// File: rtl/debug_pkg.sv
// Shared definitions for the UART debug run controller and host-side tooling.
package debug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PRST,
    RUN,
    STEP,
    DUMP_REQ,
    DUMP_WAIT,
    DONE
  } state_e;

  // Debugger command bytes; host tooling must send exactly these.
  localparam logic [7:0] CMD_RUN   = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
  localparam logic [7:0] CMD_RESET = 8'h72;  // 'r'

  localparam int CNT_W_DEFAULT = 16;
  localparam int TMR_W         = 16;

  function automatic logic is_quiet(state_e s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/debug_timeout_counter.sv
// Loadable down-counter with expiry flag; times both the pipeline reset hold
// and the dump acknowledge timeout.
module debug_timeout_counter #(
  parameter int           W    = 16,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= INIT;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/debug_run_controller.sv
// Decodes debugger command bytes and sequences the pipeline enable/reset,
// requesting a TX state dump after every step or at program end.
module debug_run_controller #(
  parameter int         CNT_W        = debug_pkg::CNT_W_DEFAULT,
  parameter int         RST_CYCLES   = 4,
  parameter int         DUMP_TIMEOUT = 65535,
  parameter logic [7:0] CMD_RUN      = debug_pkg::CMD_RUN,
  parameter logic [7:0] CMD_STEP     = debug_pkg::CMD_STEP,
  parameter logic [7:0] CMD_RESET    = debug_pkg::CMD_RESET
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_empty,
  output logic             rd_uart,
  input  logic             program_end,
  input  logic             data_sent,
  output logic             pipe_en,
  output logic             pipe_reset,
  output logic             send_data,
  output logic             busy,
  output logic             dump_timeout,
  output logic [CNT_W-1:0] cycle_count
);

  import debug_pkg::*;

  localparam logic [TMR_W-1:0] RST_LOAD  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] DUMP_LOAD = (DUMP_TIMEOUT == 0) ? '0 : TMR_W'(DUMP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  state_e           origin_q, origin_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             step_q, step_d;
  logic             tmo_d;
  logic [CNT_W-1:0] cnt_d;
  logic             pipe_en_q, pipe_reset_q, rd_uart_q, send_data_q, busy_q, dump_timeout_q;
  logic [CNT_W-1:0] cycle_count_q;

  logic             tmr_load, tmr_en, tmr_expired;
  logic [TMR_W-1:0] tmr_val;

  debug_timeout_counter #(
    .W    (TMR_W),
    .INIT (RST_LOAD)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    origin_d = origin_q;
    cmd_d    = cmd_q;
    step_d   = step_q;
    tmo_d    = dump_timeout_q;
    case (state_q)
      IDLE, DONE: begin
        if (!rx_empty) begin
          cmd_d    = rx_data;
          origin_d = state_q;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        // After program end, step/run only re-dump the halted state.
        if (cmd_q == CMD_RESET) begin
          state_d = PRST;
        end else if ((cmd_q == CMD_STEP) || (cmd_q == CMD_RUN)) begin
          if (origin_q == DONE) begin
            step_d  = 1'b0;
            state_d = DUMP_REQ;
          end else begin
            state_d = (cmd_q == CMD_STEP) ? STEP : RUN;
          end
        end else begin
          state_d = origin_q;
        end
      end
      PRST: begin
        tmo_d = 1'b0;
        if (tmr_expired) state_d = IDLE;
      end
      STEP: begin
        step_d  = 1'b1;
        state_d = DUMP_REQ;
      end
      RUN: begin
        if (program_end) begin
          step_d  = 1'b0;
          state_d = DUMP_REQ;
        end
      end
      DUMP_REQ: state_d = DUMP_WAIT;
      DUMP_WAIT: begin
        if (data_sent || ((DUMP_TIMEOUT != 0) && tmr_expired)) begin
          if (!data_sent) tmo_d = 1'b1;
          state_d = (step_q && !program_end) ? IDLE : DONE;
        end
      end
      default: state_d = PRST;
    endcase

    tmr_load = ((state_d == PRST) && (state_q != PRST)) ||
               ((state_d == DUMP_WAIT) && (state_q != DUMP_WAIT));
    tmr_val  = (state_d == DUMP_WAIT) ? DUMP_LOAD : RST_LOAD;
    tmr_en   = (state_q == PRST) || (state_q == DUMP_WAIT);

    // Count the enabled cycle that just completed; clear on pipeline reset.
    cnt_d = cycle_count_q;
    if (state_d == PRST) begin
      cnt_d = '0;
    end else if (pipe_en_q && (cycle_count_q != CNT_MAX)) begin
      cnt_d = cycle_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= PRST;
      origin_q       <= IDLE;
      cmd_q          <= '0;
      step_q         <= 1'b0;
      pipe_en_q      <= 1'b0;
      pipe_reset_q   <= 1'b1;
      rd_uart_q      <= 1'b0;
      send_data_q    <= 1'b0;
      busy_q         <= 1'b1;
      dump_timeout_q <= 1'b0;
      cycle_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      origin_q       <= origin_d;
      cmd_q          <= cmd_d;
      step_q         <= step_d;
      pipe_en_q      <= (state_d == RUN) || (state_d == STEP);
      pipe_reset_q   <= (state_d == PRST);
      rd_uart_q      <= (state_d == FETCH);
      send_data_q    <= (state_d == DUMP_REQ);
      busy_q         <= !is_quiet(state_d);
      dump_timeout_q <= tmo_d;
      cycle_count_q  <= cnt_d;
    end
  end

  assign rd_uart      = rd_uart_q;
  assign pipe_en      = pipe_en_q;
  assign pipe_reset   = pipe_reset_q;
  assign send_data    = send_data_q;
  assign busy         = busy_q;
  assign dump_timeout = dump_timeout_q;
  assign cycle_count  = cycle_count_q;

endmodule
